icache_tag_assoc: RTL and testbench

- N-way set-associative tag/valid store for the instruction cache. Successor to the direct-mapped tag array.
- Provides two combinational lookup ports: current fetch and next/prefetch fetch. Each port returns a hit and a one-hot hit way.
- Selects a refill victim per set: first invalid way, otherwise a per-set round-robin pointer.
- Supports a sequential invalidate-all sweep for fence.i. Sits between the IFU fetch pipeline and the icache data array.

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_tag_match.sv | 21 ++
 rtl/icache_tag_assoc.sv | 128 ++++++++++++
 tb/tb_icache_tag_assoc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Instruction-cache-wide constants and shared types.
// Geometry defaults used by the tag store; flush sweep state encoding.
package icache_pkg;

  localparam int ICACHE_TAG_LEN = 19;
  localparam int ICACHE_IDX_LEN = 7;
  localparam int ICACHE_WAYS    = 4;
  localparam int ICACHE_SETS    = 1 << ICACHE_IDX_LEN;
  localparam int ICACHE_WAY_LEN = $clog2(ICACHE_WAYS);

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_SWEEP = 2'd1,
    FL_DONE  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/icache_tag_match.sv
// Combinational compare of one set's WAYS tags against a lookup tag.
// Produces a one-hot hit vector (all zero when disabled or on miss).
module icache_tag_match #(
  parameter int TAG_LEN = 19,
  parameter int WAYS    = 4
) (
  input  logic [WAYS-1:0][TAG_LEN-1:0] tags_i,
  input  logic [WAYS-1:0]              valid_i,
  input  logic [TAG_LEN-1:0]           tag_i,
  input  logic                         en_i,
  output logic                         hit_o,
  output logic [WAYS-1:0]              way_o
);

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign way_o[gi] = en_i && valid_i[gi] && (tags_i[gi] == tag_i);
  end

  assign hit_o = |way_o;

endmodule

// File: rtl/icache_tag_assoc.sv
// N-way set-associative icache tag/valid store with dual lookup ports,
// per-set round-robin victim selection and a sequential flush sweep.
module icache_tag_assoc
  import icache_pkg::*;
#(
  parameter int TAG_LEN = ICACHE_TAG_LEN,
  parameter int IDX_LEN = ICACHE_IDX_LEN,
  parameter int WAYS    = ICACHE_WAYS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TAG_LEN-1:0]       lk_tag_i,
  input  logic [IDX_LEN-1:0]       lk_index_i,
  input  logic [TAG_LEN-1:0]       nx_tag_i,
  input  logic [IDX_LEN-1:0]       nx_index_i,
  output logic                     lk_hit_o,
  output logic [WAYS-1:0]          lk_way_o,
  output logic                     nx_hit_o,
  output logic [WAYS-1:0]          nx_way_o,
  input  logic                     fill_valid_i,
  input  logic [TAG_LEN-1:0]       fill_tag_i,
  input  logic [IDX_LEN-1:0]       fill_index_i,
  output logic [$clog2(WAYS)-1:0]  fill_way_o,
  input  logic                     flush_i,
  output logic                     busy_o,
  output logic                     flush_done_o
);

  localparam int SETS    = 1 << IDX_LEN;
  localparam int WAY_LEN = $clog2(WAYS);

  logic [WAYS-1:0][TAG_LEN-1:0] tag_q [SETS];
  logic [WAYS-1:0]              valid_q [SETS];
  logic [WAYS-1:0]              valid_d [SETS];
  logic [WAY_LEN-1:0]           rr_q [SETS];
  logic [WAY_LEN-1:0]           rr_d [SETS];
  flush_state_e                 state_q, state_d;
  logic [IDX_LEN-1:0]           cnt_q, cnt_d;
  logic [WAY_LEN-1:0]           victim;
  logic                         busy;
  logic                         fill_we;

  assign busy         = (state_q == FL_SWEEP);
  assign busy_o       = busy;
  assign flush_done_o = (state_q == FL_DONE);
  assign fill_we      = fill_valid_i && !busy;
  assign fill_way_o   = victim;

  icache_tag_match #(.TAG_LEN(TAG_LEN), .WAYS(WAYS)) u_lk_match (
    .tags_i  (tag_q[lk_index_i]),
    .valid_i (valid_q[lk_index_i]),
    .tag_i   (lk_tag_i),
    .en_i    (!busy),
    .hit_o   (lk_hit_o),
    .way_o   (lk_way_o)
  );

  icache_tag_match #(.TAG_LEN(TAG_LEN), .WAYS(WAYS)) u_nx_match (
    .tags_i  (tag_q[nx_index_i]),
    .valid_i (valid_q[nx_index_i]),
    .tag_i   (nx_tag_i),
    .en_i    (!busy),
    .hit_o   (nx_hit_o),
    .way_o   (nx_way_o)
  );

  // Descending scan so the lowest invalid way is the last one to win.
  always_comb begin
    victim = rr_q[fill_index_i];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[fill_index_i][w]) victim = WAY_LEN'(w);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FL_IDLE: begin
        if (flush_i) begin
          state_d = FL_SWEEP;
          cnt_d   = '0;
        end
      end
      FL_SWEEP: begin
        cnt_d = cnt_q + IDX_LEN'(1);
        if (cnt_q == IDX_LEN'(SETS - 1)) state_d = FL_DONE;
      end
      FL_DONE: state_d = FL_IDLE;
      default: state_d = FL_IDLE;
    endcase
  end

  // Fills and sweep clears never coincide: fills are blocked while sweeping.
  always_comb begin
    valid_d = valid_q;
    rr_d    = rr_q;
    if (fill_we) begin
      valid_d[fill_index_i][victim] = 1'b1;
      rr_d[fill_index_i]            = rr_q[fill_index_i] + WAY_LEN'(1);
    end
    if (busy) begin
      valid_d[cnt_q] = '0;
      rr_d[cnt_q]    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FL_IDLE;
      cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) tag_q[fill_index_i][victim] <= fill_tag_i;
  end

endmodule

// File: tb/tb_icache_tag_assoc.sv
// Self-checking bench for icache_tag_assoc: directed scenarios plus random
// traffic, all outputs compared each cycle against a per-set array model.
module tb_icache_tag_assoc;

  localparam int TAG_LEN = 19;
  localparam int IDX_LEN = 7;
  localparam int WAYS    = 4;
  localparam int SETS    = 128;

  logic                clk;
  logic                rst;
  logic [TAG_LEN-1:0]  lk_tag_i, nx_tag_i, fill_tag_i;
  logic [IDX_LEN-1:0]  lk_index_i, nx_index_i, fill_index_i;
  logic                lk_hit_o, nx_hit_o;
  logic [WAYS-1:0]     lk_way_o, nx_way_o;
  logic                fill_valid_i;
  logic [1:0]          fill_way_o;
  logic                flush_i;
  logic                busy_o;
  logic                flush_done_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit                 mvalid [SETS][WAYS];
  logic [TAG_LEN-1:0] mtag   [SETS][WAYS];
  int                 mrr    [SETS];
  int                 mleft;
  bit                 mdone;

  icache_tag_assoc dut (
    .clk          (clk),
    .rst          (rst),
    .lk_tag_i     (lk_tag_i),
    .lk_index_i   (lk_index_i),
    .nx_tag_i     (nx_tag_i),
    .nx_index_i   (nx_index_i),
    .lk_hit_o     (lk_hit_o),
    .lk_way_o     (lk_way_o),
    .nx_hit_o     (nx_hit_o),
    .nx_way_o     (nx_way_o),
    .fill_valid_i (fill_valid_i),
    .fill_tag_i   (fill_tag_i),
    .fill_index_i (fill_index_i),
    .fill_way_o   (fill_way_o),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .flush_done_o (flush_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) mvalid[s][w] = 1'b0;
    end
    mleft = 0;
    mdone = 1'b0;
  endfunction

  function automatic int mvictim(input int idx);
    for (int w = 0; w < WAYS; w++) if (!mvalid[idx][w]) return w;
    return mrr[idx];
  endfunction

  function automatic bit mpresent(input int idx, input logic [TAG_LEN-1:0] t);
    for (int w = 0; w < WAYS; w++) if (mvalid[idx][w] && mtag[idx][w] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void mlook(input int idx, input logic [TAG_LEN-1:0] t,
                                output bit hit, output logic [WAYS-1:0] way);
    hit = 1'b0;
    way = '0;
    if (mleft == 0) begin
      for (int w = 0; w < WAYS; w++) begin
        if (mvalid[idx][w] && mtag[idx][w] == t) begin
          way[w] = 1'b1;
          hit    = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_clock();
    bit nd;
    int s, v, fi;
    nd = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (mleft > 0) begin
      s = SETS - mleft;
      for (int w = 0; w < WAYS; w++) mvalid[s][w] = 1'b0;
      mrr[s] = 0;
      mleft--;
      if (mleft == 0) nd = 1'b1;
    end else begin
      if (fill_valid_i) begin
        fi = int'(fill_index_i);
        v  = mvictim(fi);
        mvalid[fi][v] = 1'b1;
        mtag[fi][v]   = fill_tag_i;
        mrr[fi]       = (mrr[fi] + 1) % WAYS;
      end
      if (flush_i && !mdone) mleft = SETS;
    end
    mdone = nd;
  endfunction

  task automatic check_all();
    bit eh;
    logic [WAYS-1:0] ew;
    mlook(int'(lk_index_i), lk_tag_i, eh, ew);
    chk("lk_hit", 32'(lk_hit_o), 32'(eh));
    chk("lk_way", 32'(lk_way_o), 32'(ew));
    mlook(int'(nx_index_i), nx_tag_i, eh, ew);
    chk("nx_hit", 32'(nx_hit_o), 32'(eh));
    chk("nx_way", 32'(nx_way_o), 32'(ew));
    chk("fill_way", 32'(fill_way_o), 32'(mvictim(int'(fill_index_i))));
    chk("busy", 32'(busy_o), 32'(mleft > 0));
    chk("done", 32'(flush_done_o), 32'(mdone));
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
    if (fill_valid_i)
      $display("fill idx=%0d tag=%05h way=%0d busy=%0b", fill_index_i, fill_tag_i, fill_way_o, busy_o);
  endtask

  task automatic advance();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic set_lk(input int idx, input int t);
    lk_index_i = IDX_LEN'(idx);
    lk_tag_i   = TAG_LEN'(t);
  endtask

  task automatic set_fill(input bit en, input int idx, input int t);
    fill_valid_i = en;
    fill_index_i = IDX_LEN'(idx);
    fill_tag_i   = TAG_LEN'(t);
  endtask

  initial begin
    int busy_cnt, done_at, done_seen, fi;
    logic [TAG_LEN-1:0] ft;

    rst = 1'b1; flush_i = 1'b0;
    set_lk(0, 0); set_fill(1'b0, 0, 0);
    nx_index_i = '0; nx_tag_i = '0;
    model_reset();
    #1;
    sample();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(flush_done_o), 32'd0);
    chk("rst_fill_way", 32'(fill_way_o), 32'd0);
    advance();
    advance();
    rst = 1'b0;

    // Fill and hit at index 5
    set_lk(5, 'h1234); set_fill(1'b0, 5, 'h1234);
    sample();
    chk("t1_miss", 32'(lk_hit_o), 32'd0);
    chk("t1_victim", 32'(fill_way_o), 32'd0);
    advance();
    set_fill(1'b1, 5, 'h1234); tick(); set_fill(1'b0, 0, 0);
    sample();
    chk("t1_hit", 32'(lk_hit_o), 32'd1);
    chk("t1_way", 32'(lk_way_o), 32'b0001);
    advance();

    // Four fills to index 9, then a round-robin replacement of way 0
    for (int i = 0; i < 4; i++) begin
      set_fill(1'b1, 9, 'h100 + i);
      sample();
      chk("t2_way", 32'(fill_way_o), 32'(i));
      advance();
    end
    set_fill(1'b1, 9, 'h104);
    sample();
    chk("t2_wrap", 32'(fill_way_o), 32'd0);
    advance();
    set_fill(1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      set_lk(9, 'h100 + i);
      sample();
      chk("t2_hit", 32'(lk_hit_o), (i == 0) ? 32'd0 : 32'd1);
      chk("t2_hway", 32'(lk_way_o), (i == 0) ? 32'd0 : ((i == 4) ? 32'd1 : 32'(1 << i)));
      advance();
    end

    // Dual port: index 3 hits in way 2 while index 4 misses
    for (int i = 0; i < 3; i++) begin
      set_fill(1'b1, 3, 'h300 + i); tick();
    end
    set_fill(1'b0, 0, 0);
    set_lk(3, 'h302); nx_index_i = 7'd4; nx_tag_i = 19'h400;
    sample();
    chk("t3_lk_hit", 32'(lk_hit_o), 32'd1);
    chk("t3_lk_way", 32'(lk_way_o), 32'b0100);
    chk("t3_nx_hit", 32'(nx_hit_o), 32'd0);
    advance();

    // Same-cycle fill and lookup at index 7
    set_lk(7, 'h777); set_fill(1'b1, 7, 'h777);
    sample();
    chk("t5_same_miss", 32'(lk_hit_o), 32'd0);
    advance();
    set_fill(1'b0, 0, 0);
    sample();
    chk("t5_next_hit", 32'(lk_hit_o), 32'd1);
    advance();

    // Random traffic over a small set/tag pool
    for (int c = 0; c < 400; c++) begin
      set_lk($urandom_range(0, 15), 'h500 + $urandom_range(0, 9));
      nx_index_i = IDX_LEN'($urandom_range(0, 15));
      nx_tag_i   = TAG_LEN'('h500 + $urandom_range(0, 9));
      fi = ($urandom_range(0, 3) == 0) ? int'(lk_index_i) : $urandom_range(0, 15);
      ft = TAG_LEN'('h500 + $urandom_range(0, 9));
      set_fill(($urandom_range(0, 1) == 1) && !mpresent(fi, ft), fi, int'(ft));
      tick();
    end
    set_fill(1'b0, 0, 0);

    // Flush sweep with a dropped fill and an ignored second flush
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    busy_cnt = 0; done_at = -1;
    for (int c = 1; c <= 135; c++) begin
      set_fill(c == 5, 20, 'h9999);
      flush_i = (c == 7);
      sample();
      if (busy_o) busy_cnt++;
      if (flush_done_o && done_at < 0) done_at = c;
      advance();
    end
    flush_i = 1'b0; set_fill(1'b0, 0, 0);
    chk("t4_busy_cycles", 32'(busy_cnt), 32'd128);
    chk("t4_done_cycle", 32'(done_at), 32'd129);
    set_lk(5, 'h1234); sample(); chk("t4_miss5", 32'(lk_hit_o), 32'd0); advance();
    set_lk(9, 'h101);  sample(); chk("t4_miss9", 32'(lk_hit_o), 32'd0); advance();
    set_lk(20, 'h9999); sample(); chk("t4_dropped", 32'(lk_hit_o), 32'd0); advance();

    // Reset in the middle of a sweep
    for (int i = 0; i < 4; i++) begin
      set_fill(1'b1, 30 + i, 'h600 + i); tick();
    end
    set_fill(1'b0, 0, 0);
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    for (int c = 1; c <= 40; c++) tick();
    rst = 1'b1;
    #1;
    chk("t6_busy_now", 32'(busy_o), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 140; c++) begin
      set_lk(30 + (c % 4), 'h600 + (c % 4));
      nx_index_i = IDX_LEN'(c % SETS);
      nx_tag_i   = TAG_LEN'('h500 + (c % 10));
      sample();
      if (flush_done_o) done_seen++;
      chk("t6_miss", 32'(lk_hit_o), 32'd0);
      advance();
    end
    chk("t6_no_done", 32'(done_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
